// File: rtl/mips_seq_ctrl_if.sv
// Instruction/data memory req-ack handshake bundle shared by the sequencer and its memories.
interface mips_seq_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit MIPS-style datapath.
// Optional retired-instruction counter enabled by defining MIPS_SEQ_RETIRE_CNT_EN.
module mips_seq_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            opcode,
  input  logic                  zero,
  mips_seq_ctrl_if.master       mem,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic [1:0]            pc_src,
  output logic                  alu_src,
  output logic [1:0]            alu_ctrl,
  output logic                  mem_to_reg,
  output logic                  upper,
  output logic                  reg_we,
  output logic                  li_pending,
  output logic                  busy,
  output logic                  err
`ifdef MIPS_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]           retired
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [2:0] OP_LI   = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_SLTI = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_J    = 3'b111;

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              li_pending_q, li_pending_d;
  logic              retire;
  logic [2:0]        alu_sel;

  // {alu_src, alu_ctrl}; li loads the upper half first (pass-upper), then adds the lower half
  function automatic logic [2:0] alu_decode(input logic [2:0] op, input logic lp);
    case (op)
      OP_LI:                alu_decode = lp ? 3'b100 : 3'b111;
      OP_LW, OP_SW, OP_ADDI: alu_decode = 3'b100;
      OP_SLTI:              alu_decode = 3'b110;
      OP_BEQ:               alu_decode = 3'b001;
      default:              alu_decode = 3'b000;
    endcase
  endfunction

  assign alu_sel = alu_decode(opcode, li_pending_q);

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    li_pending_d = li_pending_q;
    retire       = 1'b0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    alu_src      = 1'b0;
    alu_ctrl     = 2'b00;
    mem_to_reg   = 1'b0;
    upper        = 1'b0;
    reg_we       = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_src  = alu_sel[2];
      alu_ctrl = alu_sel[1:0];
    end
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + 1'b1;
          if (WAIT_MAX != 0 && wait_d == WAIT_LIM) state_d = S_ERR;
        end
      end
      S_DECODE: begin
        if (opcode != OP_LI) li_pending_d = 1'b0;
        if (opcode == OP_J) begin
          pc_we   = 1'b1;
          pc_src  = 2'b10;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (opcode == OP_BEQ) begin
          pc_we   = zero;
          pc_src  = zero ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (opcode == OP_SW);
        if (mem.dmem_ack) begin
          retire  = (opcode == OP_SW);
          state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
        end else begin
          wait_d = wait_q + 1'b1;
          if (WAIT_MAX != 0 && wait_d == WAIT_LIM) state_d = S_ERR;
        end
      end
      S_WB: begin
        reg_we       = 1'b1;
        mem_to_reg   = (opcode == OP_LW) || (opcode == OP_LI);
        upper        = (opcode == OP_LI);
        li_pending_d = (opcode == OP_LI) ? ~li_pending_q : 1'b0;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
    // A reset cycle aborts whatever the state was doing: no strobe or request leaves the block
    if (reset) begin
      retire       = 1'b0;
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      mem.dmem_we  = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'b00;
      alu_src      = 1'b0;
      alu_ctrl     = 2'b00;
      mem_to_reg   = 1'b0;
      upper        = 1'b0;
      reg_we       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      wait_q       <= '0;
      li_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      li_pending_q <= li_pending_d;
    end
  end

  assign li_pending = li_pending_q;
  assign busy       = (state_q != S_ERR);
  assign err        = (state_q == S_ERR);

`ifdef MIPS_SEQ_RETIRE_CNT_EN
  logic [15:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Directed bench for mips_seq_ctrl: per-cycle snapshots compared against hand-derived values.
module tb_mips_seq_ctrl;
  localparam logic [2:0] LI = 3'b000, LW = 3'b001, SW = 3'b010, ADDI = 3'b011;
  localparam logic [2:0] BEQ = 3'b100, ADD = 3'b110, J = 3'b111;

  logic clk;
  logic reset;
  logic [2:0] opcode;
  logic zero;
  logic ir_we, pc_we, alu_src, mem_to_reg, upper, reg_we, li_pending, busy, err;
  logic [1:0] pc_src, alu_ctrl;
`ifdef MIPS_SEQ_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  mips_seq_ctrl_if mem_if ();

  mips_seq_ctrl #(.WAIT_MAX(4), .WAIT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mem_if.master),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .mem_to_reg (mem_to_reg),
    .upper      (upper),
    .reg_we     (reg_we),
    .li_pending (li_pending),
    .busy       (busy),
    .err        (err)
`ifdef MIPS_SEQ_RETIRE_CNT_EN
    ,
    .retired    (retired)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic s_imem, s_dmem, s_dwe, s_ir, s_pcwe, s_asrc, s_m2r, s_up, s_rwe, s_lip, s_busy, s_err;
  logic [1:0] s_pcsrc, s_actl;

  // Apply one cycle of inputs, capture the settled outputs, then advance past the clock edge
  task automatic cyc(input logic rst, input logic [2:0] op, input logic z,
                     input logic ia, input logic da);
    reset = rst; opcode = op; zero = z;
    mem_if.imem_ack = ia; mem_if.dmem_ack = da;
    #1;
    s_imem = mem_if.imem_req; s_dmem = mem_if.dmem_req; s_dwe = mem_if.dmem_we;
    s_ir = ir_we; s_pcwe = pc_we; s_pcsrc = pc_src; s_asrc = alu_src; s_actl = alu_ctrl;
    s_m2r = mem_to_reg; s_up = upper; s_rwe = reg_we; s_lip = li_pending;
    s_busy = busy; s_err = err;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
    checks++; if ({s_imem, s_dmem, s_ir, s_pcwe, s_rwe} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {s_imem, s_dmem, s_ir, s_pcwe, s_rwe}); end
    cyc(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (s_imem !== 1'b1) begin errors++; $display("FAIL reset_fetch_req: got %b want 1", s_imem); end
    checks++; if ({s_busy, s_err, s_lip} !== 3'b100) begin errors++; $display("FAIL reset_flags busy/err/lip: got %b want 100", {s_busy, s_err, s_lip}); end
  endtask

  task automatic test_alu_pair();
    logic any_dmem;
    any_dmem = 1'b0;
    do_reset();
    cyc(1'b0, ADD, 1'b0, 1'b1, 1'b0); any_dmem |= s_dmem;
    checks++; if ({s_ir, s_pcwe, s_pcsrc} !== 4'b1100) begin errors++; $display("FAIL add_fetch ir/pc/src: got %b want 1100", {s_ir, s_pcwe, s_pcsrc}); end
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0); any_dmem |= s_dmem;
    checks++; if ({s_pcwe, s_rwe} !== 2'b00) begin errors++; $display("FAIL add_decode_quiet: got %b want 00", {s_pcwe, s_rwe}); end
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0); any_dmem |= s_dmem;
    checks++; if ({s_asrc, s_actl} !== 3'b000) begin errors++; $display("FAIL add_exec_alu: got %b want 000", {s_asrc, s_actl}); end
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0); any_dmem |= s_dmem;
    checks++; if ({s_rwe, s_m2r, s_up} !== 3'b100) begin errors++; $display("FAIL add_wb c4: got %b want 100", {s_rwe, s_m2r, s_up}); end
    cyc(1'b0, ADDI, 1'b0, 1'b1, 1'b0); any_dmem |= s_dmem;
    checks++; if (s_ir !== 1'b1) begin errors++; $display("FAIL addi_fetch c5 ir_we: got %b want 1", s_ir); end
    cyc(1'b0, ADDI, 1'b0, 1'b0, 1'b0); any_dmem |= s_dmem;
    cyc(1'b0, ADDI, 1'b0, 1'b0, 1'b0); any_dmem |= s_dmem;
    checks++; if ({s_asrc, s_actl} !== 3'b100) begin errors++; $display("FAIL addi_exec_alu: got %b want 100", {s_asrc, s_actl}); end
    cyc(1'b0, ADDI, 1'b0, 1'b0, 1'b0); any_dmem |= s_dmem;
    checks++; if ({s_rwe, s_m2r} !== 2'b10) begin errors++; $display("FAIL addi_wb c8: got %b want 10", {s_rwe, s_m2r}); end
    checks++; if (any_dmem !== 1'b0) begin errors++; $display("FAIL alu_no_dmem: got %b want 0", any_dmem); end
  endtask

  task automatic test_lw_wait();
    int req_cnt;
    logic any_we;
    req_cnt = 0; any_we = 1'b0;
    do_reset();
    cyc(1'b0, LW, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, LW, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, LW, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_asrc, s_actl} !== 3'b100) begin errors++; $display("FAIL lw_exec_alu: got %b want 100", {s_asrc, s_actl}); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, LW, 1'b0, 1'b0, (i == 3));
      if (s_dmem) req_cnt++;
      any_we |= s_dwe;
    end
    checks++; if (req_cnt != 4) begin errors++; $display("FAIL lw_dmem_req_cycles: got %0d want 4", req_cnt); end
    checks++; if (any_we !== 1'b0) begin errors++; $display("FAIL lw_dmem_we: got %b want 0", any_we); end
    cyc(1'b0, LW, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_rwe, s_m2r, s_err} !== 3'b110) begin errors++; $display("FAIL lw_wb c8 rwe/m2r/err: got %b want 110", {s_rwe, s_m2r, s_err}); end
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_imem, s_dmem} !== 2'b10) begin errors++; $display("FAIL lw_next_fetch c9: got %b want 10", {s_imem, s_dmem}); end
  endtask

  task automatic test_beq();
    do_reset();
    cyc(1'b0, BEQ, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, BEQ, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, BEQ, 1'b1, 1'b0, 1'b0);
    checks++; if ({s_pcwe, s_pcsrc, s_actl} !== 5'b10101) begin errors++; $display("FAIL beq_taken pcwe/src/actl: got %b want 10101", {s_pcwe, s_pcsrc, s_actl}); end
    cyc(1'b0, BEQ, 1'b0, 1'b1, 1'b0);
    checks++; if (s_ir !== 1'b1) begin errors++; $display("FAIL beq_3cyc_refetch: got %b want 1", s_ir); end
    cyc(1'b0, BEQ, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, BEQ, 1'b0, 1'b0, 1'b0);
    checks++; if (s_pcwe !== 1'b0) begin errors++; $display("FAIL beq_not_taken pc_we: got %b want 0", s_pcwe); end
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0);
    checks++; if (s_imem !== 1'b1) begin errors++; $display("FAIL beq_nt_refetch: got %b want 1", s_imem); end
  endtask

  task automatic test_jump_sw();
    do_reset();
    cyc(1'b0, J, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, J, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_pcwe, s_pcsrc} !== 3'b110) begin errors++; $display("FAIL j_decode pcwe/src: got %b want 110", {s_pcwe, s_pcsrc}); end
    cyc(1'b0, SW, 1'b0, 1'b1, 1'b0);
    checks++; if (s_ir !== 1'b1) begin errors++; $display("FAIL j_2cyc_refetch: got %b want 1", s_ir); end
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b1);
    checks++; if ({s_dmem, s_dwe, s_rwe} !== 3'b110) begin errors++; $display("FAIL sw_mem req/we/rwe: got %b want 110", {s_dmem, s_dwe, s_rwe}); end
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_imem, s_rwe} !== 2'b10) begin errors++; $display("FAIL sw_4cyc_refetch: got %b want 10", {s_imem, s_rwe}); end
  endtask

  task automatic test_li_chain();
    do_reset();
    cyc(1'b0, LI, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, LI, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, LI, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_asrc, s_actl} !== 3'b111) begin errors++; $display("FAIL li1_exec_alu: got %b want 111", {s_asrc, s_actl}); end
    cyc(1'b0, LI, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_up, s_actl, s_rwe, s_m2r} !== 5'b11111) begin errors++; $display("FAIL li1_wb up/actl/rwe/m2r: got %b want 11111", {s_up, s_actl, s_rwe, s_m2r}); end
    cyc(1'b0, LI, 1'b0, 1'b1, 1'b0);
    checks++; if (s_lip !== 1'b1) begin errors++; $display("FAIL li1_pending: got %b want 1", s_lip); end
    cyc(1'b0, LI, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, LI, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, LI, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_up, s_actl} !== 3'b100) begin errors++; $display("FAIL li2_wb up/actl: got %b want 100", {s_up, s_actl}); end
    cyc(1'b0, LI, 1'b0, 1'b1, 1'b0);
    checks++; if (s_lip !== 1'b0) begin errors++; $display("FAIL li2_pending: got %b want 0", s_lip); end
    cyc(1'b0, LI, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, LI, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, LI, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_up, s_actl} !== 3'b111) begin errors++; $display("FAIL li3_wb up/actl: got %b want 111", {s_up, s_actl}); end
    cyc(1'b0, ADDI, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, ADDI, 1'b0, 1'b0, 1'b0);
    checks++; if (s_lip !== 1'b1) begin errors++; $display("FAIL li3_pending_at_decode: got %b want 1", s_lip); end
    cyc(1'b0, ADDI, 1'b0, 1'b0, 1'b0);
    checks++; if (s_lip !== 1'b0) begin errors++; $display("FAIL orphan_li_cleared: got %b want 0", s_lip); end
    cyc(1'b0, ADDI, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_rwe, s_up, s_m2r} !== 3'b100) begin errors++; $display("FAIL orphan_addi_wb: got %b want 100", {s_rwe, s_up, s_m2r}); end
  endtask

  task automatic test_timeout();
    logic early_err;
    early_err = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0);
      early_err |= s_err | ~s_imem;
    end
    checks++; if (early_err !== 1'b0) begin errors++; $display("FAIL timeout_wait_phase err|!req: got %b want 0", early_err); end
    cyc(1'b0, ADD, 1'b0, 1'b1, 1'b0);
    checks++; if ({s_err, s_busy, s_imem, s_ir} !== 4'b1000) begin errors++; $display("FAIL timeout_err err/busy/req/ir: got %b want 1000", {s_err, s_busy, s_imem, s_ir}); end
    cyc(1'b0, ADD, 1'b0, 1'b1, 1'b1);
    checks++; if ({s_err, s_ir, s_dmem} !== 3'b100) begin errors++; $display("FAIL err_sticky_ack_ignored: got %b want 100", {s_err, s_ir, s_dmem}); end
    do_reset();
    cyc(1'b0, ADD, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_imem, s_err, s_busy} !== 3'b101) begin errors++; $display("FAIL err_reset_recovery: got %b want 101", {s_imem, s_err, s_busy}); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    cyc(1'b0, SW, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, SW, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_dmem, s_dwe} !== 2'b11) begin errors++; $display("FAIL sw_mem_before_reset: got %b want 11", {s_dmem, s_dwe}); end
    cyc(1'b1, SW, 1'b0, 1'b0, 1'b1);
    checks++; if ({s_dmem, s_dwe} !== 2'b00) begin errors++; $display("FAIL reset_in_mem_strobes: got %b want 00", {s_dmem, s_dwe}); end
    cyc(1'b0, ADD, 1'b0, 1'b1, 1'b1);
    checks++; if ({s_dmem, s_imem, s_ir, s_lip} !== 4'b0110) begin errors++; $display("FAIL reset_in_mem_after dmem/imem/ir/lip: got %b want 0110", {s_dmem, s_imem, s_ir, s_lip}); end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1; opcode = 3'b000; zero = 1'b0;
    mem_if.imem_ack = 1'b0; mem_if.dmem_ack = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_alu_pair();
    test_lw_wait();
    test_beq();
    test_jump_sw();
    test_li_chain();
    test_timeout();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_seq_ctrl.md
Name: mips_seq_ctrl

Overview:
- Multi-cycle sequencer for the 8-bit MIPS-style datapath. Each instruction is walked through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath's per-cycle strobes: IR load, PC update, register write, data-memory request.
- Handles req/ack handshakes to instruction and data memory.
- Tracks the two-word li pair (upper half, then lower half) in an internal flag. No bidirectional signal is used.

Parameters:
- WAIT_MAX, 15: max cycles to wait for a memory ack before ERR; 0 disables the timeout.
- WAIT_W, 4: width of the wait counter; must hold WAIT_MAX.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  3  IR[7:5] from the datapath IR; valid from DECODE onward
- zero  in  1  ALU zero flag; sampled in EXEC of beq
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write (sw)
- dmem_ack  in  1  data access complete this cycle
- ir_we  out  1  load IR
- pc_we  out  1  update PC
- pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- alu_src  out  1  1 = immediate operand
- alu_ctrl  out  2  00 add, 01 sub/compare, 10 slt, 11 pass-upper
- mem_to_reg  out  1  1 = writeback from memory/immediate path
- upper  out  1  li half-select to datapath (M)
- reg_we  out  1  register file write
- li_pending  out  1  first li half done, awaiting second
- busy  out  1  high in every state except ERR
- err  out  1  memory timeout; sticky until reset

Behaviour:
- Reset is synchronous: state = FETCH, li_pending = 0, wait counter = 0, err = 0. All strobes are 0 during the reset cycle.
- Unused outputs are always driven 0, never z.
- Opcodes: 000 li, 001 lw, 010 sw, 011 addi, 100 beq, 101 slti, 110 add, 111 j.
- FETCH:
  - imem_req = 1 until imem_ack.
  - In the ack cycle: ir_we = 1, pc_we = 1, pc_src = 00, then go to DECODE.
- DECODE (1 cycle):
  - j: pc_we = 1, pc_src = 10, then FETCH.
  - All other opcodes: go to EXEC.
- EXEC (1 cycle): alu_src and alu_ctrl are held per opcode.
  - addi 1/00, slti 1/10, add 0/00, lw/sw 1/00, beq 0/01.
  - li with li_pending = 0: 1/11. li with li_pending = 1: 1/00.
  - beq: if zero = 1, pc_we = 1, pc_src = 01. Then FETCH.
  - lw/sw: go to MEM.
  - Others: go to WB.
- MEM:
  - dmem_req = 1 (dmem_we = 1 for sw), alu controls held, until dmem_ack.
  - On ack: sw goes to FETCH, lw goes to WB.
- WB (1 cycle), reg_we = 1, alu controls held:
  - mem_to_reg = 1 for lw/li, 0 for addi/slti/add.
  - upper = 1 for li.
  - li toggles li_pending. Any other writeback clears it.
- Orphan li: if a non-li instruction is decoded while li_pending = 1, li_pending clears in DECODE and the instruction executes normally.
- Latency with zero-wait memory (ack in the first request cycle):
  - j: 2 cycles
  - beq: 3 cycles
  - add/addi/slti/li/sw: 4 cycles
  - lw: 5 cycles
  - Each extra wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH/MEM; increments each non-ack cycle there.
  - If it reaches WAIT_MAX (WAIT_MAX > 0) with no ack: go to ERR.
  - An ack in the same cycle the counter reaches WAIT_MAX wins (no error).
- ERR: err = 1, busy = 0, all strobes 0, no requests. Exit only by reset.
- Reset asserted mid-operation (including during MEM or WB) aborts with no strobe in that cycle and returns to FETCH.
- An ack arriving outside its request state is ignored.

Optional Feature:
- Macro: MIPS_SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output retired (16 bits).
  - Increments on each instruction's final cycle: WB, sw MEM ack, beq EXEC, j DECODE.
  - Wraps 0xFFFF -> 0x0000. Reset to 0; frozen in ERR.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Zero-wait add (opcode 110), then addi (011). Required:
  - ir_we at cycle 1.
  - reg_we at cycles 4 and 8.
  - alu_src 0 then 1.
  - No dmem_req.
- lw with dmem_ack delayed 3 cycles. Required:
  - dmem_req high for 4 cycles, dmem_we = 0.
  - reg_we with mem_to_reg = 1 one cycle after the ack.
  - Total 8 cycles.
- beq with zero = 1, then beq with zero = 0. Required:
  - First: pc_we = 1, pc_src = 01 in EXEC.
  - Second: no EXEC pc_we.
  - Each takes 3 cycles.
- li, li, li, addi. Required:
  - upper = 1 with alu_ctrl 11, then 00, then 11.
  - li_pending goes 1, 0, 1, then cleared by addi.
- WAIT_MAX = 4, imem_ack never asserted. Required:
  - err = 1 after the 4th wait cycle; busy = 0.
  - reset then restores FETCH with imem_req = 1.
- reset asserted during the MEM state of sw. Required:
  - dmem_req = 0 in the next cycle.
  - State FETCH; li_pending = 0.
